// File: rtl/lpc_tpm_trigger.sv
// rtl/lpc_tpm_trigger.sv - passive LPC TPM cycle decoder with address/direction trigger
module lpc_tpm_trigger #(
    parameter logic [15:0] ADDR_MATCH    = 16'h0024,
    parameter logic [15:0] ADDR_MASK     = 16'hFFFF,
    parameter bit          TRIG_ON_READ  = 1'b1,
    parameter bit          TRIG_ON_WRITE = 1'b1,
    parameter int          MAX_SYNC_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lpc_frame,
    input  logic [3:0]  lpc_ad,
    output logic        cycle_valid,
    output logic        trigger,
    output logic        cyc_write,
    output logic [15:0] cyc_addr,
    output logic [7:0]  cyc_data
);

    localparam int WW = (MAX_SYNC_WAIT > 0) ? $clog2(MAX_SYNC_WAIT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_WDATA,
        S_TAR,
        S_SYNC,
        S_RDATA,
        S_COMPLETE
    } state_t;

    state_t         state, state_n;
    logic [1:0]     cnt, cnt_n;
    logic [WW-1:0]  wait_cnt, wait_n;
    logic [3:0]     start_nib;
    logic           is_write;
    logic [15:0]    addr;
    logic [7:0]     data;
    logic           done;
    logic [7:0]     fin_data;
    logic           hit;
    logic           dir_ok;

    // State, nibble counter and SYNC wait counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= 2'd0;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            wait_cnt <= wait_n;
        end
    end

    // Next-state decode; LFRAME# low always wins and restarts decoding
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wait_n  = wait_cnt;
        done    = 1'b0;
        if (!lpc_frame) begin
            state_n = S_START;
            cnt_n   = 2'd0;
            wait_n  = '0;
        end else begin
            case (state)
                S_IDLE: state_n = S_IDLE;
                S_START: begin
                    // cycle type is sampled in the first clk after LFRAME# rises
                    if (start_nib == 4'b0101 && lpc_ad[3:2] == 2'b00) begin
                        state_n = S_ADDR;
                        cnt_n   = 2'd0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
                S_ADDR: begin
                    cnt_n = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state_n = is_write ? S_WDATA : S_TAR;
                        cnt_n   = 2'd0;
                    end
                end
                S_WDATA: begin
                    cnt_n = cnt + 2'd1;
                    if (cnt == 2'd1) begin
                        state_n = S_TAR;
                        cnt_n   = 2'd0;
                    end
                end
                S_TAR: begin
                    cnt_n = cnt + 2'd1;
                    if (cnt == 2'd1) begin
                        state_n = S_SYNC;
                        cnt_n   = 2'd0;
                        wait_n  = '0;
                    end
                end
                S_SYNC: begin
                    if (lpc_ad == 4'b0000) begin
                        if (is_write) begin
                            state_n = S_COMPLETE;
                            done    = 1'b1;
                        end else begin
                            state_n = S_RDATA;
                            cnt_n   = 2'd0;
                        end
                    end else if (lpc_ad == 4'b0101 || lpc_ad == 4'b0110) begin
                        if (wait_cnt == WW'(MAX_SYNC_WAIT)) begin
                            state_n = S_IDLE;
                        end else begin
                            wait_n = wait_cnt + WW'(1);
                        end
                    end else begin
                        state_n = S_IDLE;
                    end
                end
                S_RDATA: begin
                    cnt_n = cnt + 2'd1;
                    if (cnt == 2'd1) begin
                        state_n = S_COMPLETE;
                        done    = 1'b1;
                    end
                end
                S_COMPLETE: state_n = S_IDLE;
                default:    state_n = S_IDLE;
            endcase
        end
    end

    // Final data byte: for reads the high nibble is on LAD in the completing clk
    always_comb begin
        fin_data = is_write ? data : {lpc_ad, data[3:0]};
        hit      = ((addr ^ ADDR_MATCH) & ADDR_MASK) == 16'h0000;
        dir_ok   = is_write ? TRIG_ON_WRITE : TRIG_ON_READ;
    end

    // Capture path: start nibble, direction, address, data and the reported cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_nib   <= 4'h0;
            is_write    <= 1'b0;
            addr        <= 16'h0000;
            data        <= 8'h00;
            cycle_valid <= 1'b0;
            trigger     <= 1'b0;
            cyc_write   <= 1'b0;
            cyc_addr    <= 16'h0000;
            cyc_data    <= 8'h00;
        end else begin
            if (!lpc_frame) begin
                start_nib <= lpc_ad;
            end
            if (state == S_START) begin
                is_write <= lpc_ad[1];
            end
            if (state == S_ADDR) begin
                addr <= {addr[11:0], lpc_ad};
            end
            if (state == S_WDATA || state == S_RDATA) begin
                if (cnt[0] == 1'b0) begin
                    data[3:0] <= lpc_ad;
                end else begin
                    data[7:4] <= lpc_ad;
                end
            end
            cycle_valid <= done;
            trigger     <= done && hit && dir_ok;
            if (done) begin
                cyc_write <= is_write;
                cyc_addr  <= addr;
                cyc_data  <= fin_data;
            end
        end
    end

endmodule
